trap_controller: RTL and testbench

Machine-mode trap sequencer that consumes the registered `address_exception` flag from the address-check stage, plus the illegal-instruction and ecall flags from decode. On a trap it flushes the pipeline and saves `mepc`, `mcause` and `mtval`. It then redirects fetch to the trap vector and holds the handler until `mret`, which it returns through. Its `exception_sig` output feeds back to the address-check stage to clear that stage's flag.

---
 rtl/trap_controller.sv | 167 ++++++++++++++++
 tb/tb_trap_controller.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/trap_controller.sv
// Machine-mode trap sequencer: takes a trap, saves mepc/mcause/mtval, redirects
// fetch to MTVEC, holds the handler until mret, then returns to mepc.
module trap_controller #(
    parameter logic [31:0] MTVEC = 32'h0000_0400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        address_exception,
    input  logic        illegal_instr,
    input  logic        ecall,
    input  logic        mret_sig,
    input  logic [31:0] exception_pc,
    input  logic [31:0] fault_addr,
    output logic        exception_sig,
    output logic        flush,
    output logic        pc_redirect,
    output logic [31:0] redirect_pc,
    output logic [31:0] mepc,
    output logic [31:0] mcause,
    output logic [31:0] mtval,
    output logic        in_trap,
    output logic        double_fault
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FLUSH    = 3'd1,
        ST_REDIRECT = 3'd2,
        ST_HANDLER  = 3'd3,
        ST_RETURN   = 3'd4
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic        exc_any_s;
    logic        capture_s;
    logic        df_set_s;
    logic [31:0] cause_s;
    logic [31:0] tval_s;
    logic        exc_sig_s;
    logic        flush_s;
    logic        redir_s;
    logic [31:0] redir_pc_s;
    logic        in_trap_s;

    assign exc_any_s = address_exception | illegal_instr | ecall;
    assign capture_s = (state_r == ST_IDLE) && exc_any_s;
    assign df_set_s  = (state_r == ST_HANDLER) && exc_any_s;

    // Cause priority: address fault over illegal instruction over ecall.
    always_comb begin
        cause_s = 32'd0;
        tval_s  = 32'd0;
        if (address_exception) begin
            cause_s = 32'd5;
            tval_s  = fault_addr;
        end else if (illegal_instr) begin
            cause_s = 32'd2;
            tval_s  = 32'd0;
        end else if (ecall) begin
            cause_s = 32'd11;
            tval_s  = 32'd0;
        end else begin
            cause_s = 32'd0;
            tval_s  = 32'd0;
        end
    end

    // Next-state logic; mret is only honoured in HANDLER.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (exc_any_s) begin
                    next_state_s = ST_FLUSH;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_FLUSH:    next_state_s = ST_REDIRECT;
            ST_REDIRECT: next_state_s = ST_HANDLER;
            ST_HANDLER: begin
                if (mret_sig) begin
                    next_state_s = ST_RETURN;
                end else begin
                    next_state_s = ST_HANDLER;
                end
            end
            ST_RETURN:   next_state_s = ST_IDLE;
            default:     next_state_s = ST_IDLE;
        endcase
    end

    // Output decode of the current state; registered below so outputs lag state by one edge.
    always_comb begin
        exc_sig_s  = 1'b0;
        flush_s    = 1'b0;
        redir_s    = 1'b0;
        redir_pc_s = 32'd0;
        in_trap_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                in_trap_s = 1'b0;
            end
            ST_FLUSH: begin
                exc_sig_s = 1'b1;
                flush_s   = 1'b1;
                in_trap_s = 1'b1;
            end
            ST_REDIRECT: begin
                redir_s    = 1'b1;
                redir_pc_s = MTVEC;
                flush_s    = 1'b1;
                in_trap_s  = 1'b1;
            end
            ST_HANDLER: begin
                in_trap_s = 1'b1;
            end
            ST_RETURN: begin
                redir_s    = 1'b1;
                redir_pc_s = mepc;
                flush_s    = 1'b1;
                in_trap_s  = 1'b1;
            end
            default: begin
                in_trap_s = 1'b0;
            end
        endcase
    end

    // State register, registered strobes and sticky double-fault flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            exception_sig <= 1'b0;
            flush         <= 1'b0;
            pc_redirect   <= 1'b0;
            redirect_pc   <= 32'd0;
            in_trap       <= 1'b0;
            double_fault  <= 1'b0;
        end else begin
            state_r       <= next_state_s;
            exception_sig <= exc_sig_s;
            flush         <= flush_s;
            pc_redirect   <= redir_s;
            redirect_pc   <= redir_pc_s;
            in_trap       <= in_trap_s;
            if (df_set_s) begin
                double_fault <= 1'b1;
            end
        end
    end

    // Trap CSRs, captured only on the IDLE-to-FLUSH transition.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mepc   <= 32'd0;
            mcause <= 32'd0;
            mtval  <= 32'd0;
        end else if (capture_s) begin
            mepc   <= exception_pc;
            mcause <= cause_s;
            mtval  <= tval_s;
        end
    end

endmodule

// File: tb/tb_trap_controller.sv
// Scoreboard bench for trap_controller: stimulus queues expected trap entries and
// redirects; a negedge monitor pops and compares whenever the DUT strobes.
module tb_trap_controller;

    logic        clk;
    logic        reset;
    logic        address_exception;
    logic        illegal_instr;
    logic        ecall;
    logic        mret_sig;
    logic [31:0] exception_pc;
    logic [31:0] fault_addr;
    logic        exception_sig;
    logic        flush;
    logic        pc_redirect;
    logic [31:0] redirect_pc;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic        in_trap;
    logic        double_fault;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] cause;
        logic [31:0] tval;
    } entry_t;

    entry_t      entry_q[$];
    logic [31:0] redir_q[$];
    int          errors = 0;
    int          checks = 0;
    logic        prev_exc = 1'b0;
    logic        prev_redir = 1'b0;

    trap_controller #(.MTVEC(32'h0000_0400)) dut (
        .clk              (clk),
        .reset            (reset),
        .address_exception(address_exception),
        .illegal_instr    (illegal_instr),
        .ecall            (ecall),
        .mret_sig         (mret_sig),
        .exception_pc     (exception_pc),
        .fault_addr       (fault_addr),
        .exception_sig    (exception_sig),
        .flush            (flush),
        .pc_redirect      (pc_redirect),
        .redirect_pc      (redirect_pc),
        .mepc             (mepc),
        .mcause           (mcause),
        .mtval            (mtval),
        .in_trap          (in_trap),
        .double_fault     (double_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_exc"},   {31'd0, exception_sig}, 32'd0);
        check({tag, "_flush"}, {31'd0, flush}, 32'd0);
        check({tag, "_redir"}, {31'd0, pc_redirect}, 32'd0);
        check({tag, "_rpc"},   redirect_pc, 32'd0);
        check({tag, "_mepc"},  mepc, 32'd0);
        check({tag, "_mcause"}, mcause, 32'd0);
        check({tag, "_mtval"}, mtval, 32'd0);
        check({tag, "_intrap"}, {31'd0, in_trap}, 32'd0);
        check({tag, "_df"},    {31'd0, double_fault}, 32'd0);
    endtask

    // Raise flags for 'hold' sampling edges, then land in the HANDLER-output cycle.
    task automatic trap(input logic [31:0] pc, input logic [31:0] fa,
                        input logic ae, input logic ii, input logic ec,
                        input logic [31:0] cause, input logic [31:0] tval, input int hold);
        entry_t e;
        e.pc = pc; e.cause = cause; e.tval = tval;
        entry_q.push_back(e);
        redir_q.push_back(32'h0000_0400);
        exception_pc = pc; fault_addr = fa;
        address_exception = ae; illegal_instr = ii; ecall = ec;
        step(hold);
        address_exception = 1'b0; illegal_instr = 1'b0; ecall = 1'b0;
        step(4 - hold);
        check("handler_intrap", {31'd0, in_trap}, 32'd1);
        check("handler_flush", {31'd0, flush}, 32'd0);
    endtask

    // Pulse mret (optionally with an ecall) and wait for the IDLE-output cycle.
    task automatic ret(input logic [31:0] pc, input logic with_ecall);
        redir_q.push_back(pc);
        mret_sig = 1'b1;
        ecall = with_ecall;
        exception_pc = 32'h0000_0999;
        step(1);
        mret_sig = 1'b0;
        ecall = 1'b0;
        step(2);
        check("ret_intrap", {31'd0, in_trap}, 32'd0);
        check("ret_mepc", mepc, pc);
    endtask

    // Monitor: pops expected responses when the DUT strobes.
    always @(negedge clk) begin
        if (exception_sig) begin
            check("exc_width", {31'd0, prev_exc}, 32'd0);
            if (entry_q.size() == 0) begin
                check("exc_unexpected", 32'd1, 32'd0);
            end else begin
                entry_t e;
                e = entry_q.pop_front();
                check("entry_mepc", mepc, e.pc);
                check("entry_mcause", mcause, e.cause);
                check("entry_mtval", mtval, e.tval);
                check("entry_flush", {31'd0, flush}, 32'd1);
                check("entry_intrap", {31'd0, in_trap}, 32'd1);
            end
        end
        if (pc_redirect) begin
            check("redir_width", {31'd0, prev_redir}, 32'd0);
            if (redir_q.size() == 0) begin
                check("redir_unexpected", 32'd1, 32'd0);
            end else begin
                logic [31:0] t;
                t = redir_q.pop_front();
                check("redir_pc", redirect_pc, t);
                check("redir_flush", {31'd0, flush}, 32'd1);
            end
        end
        prev_exc = exception_sig;
        prev_redir = pc_redirect;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        address_exception = 1'b0; illegal_instr = 1'b0; ecall = 1'b0; mret_sig = 1'b0;
        exception_pc = 32'd0; fault_addr = 32'd0;
        step(3);
        check_all_zero("reset");
        reset = 1'b1;
        step(2);
        check_all_zero("post_reset");

        // mret while idle is ignored
        mret_sig = 1'b1;
        step(1);
        mret_sig = 1'b0;
        step(2);

        // address fault
        trap(32'h0000_0120, 32'h0000_0900, 1'b1, 1'b0, 1'b0, 32'd5, 32'h0000_0900, 1);
        ret(32'h0000_0120, 1'b0);

        // all three flags: address fault wins
        trap(32'h0000_0200, 32'h0000_0abc, 1'b1, 1'b1, 1'b1, 32'd5, 32'h0000_0abc, 1);
        ret(32'h0000_0200, 1'b0);

        // illegal + ecall held through FLUSH/REDIRECT: illegal wins, no double fault
        trap(32'h0000_0300, 32'h0000_0777, 1'b0, 1'b1, 1'b1, 32'd2, 32'd0, 3);
        check("no_df", {31'd0, double_fault}, 32'd0);
        ret(32'h0000_0300, 1'b0);

        // ecall, then ecall together with mret in HANDLER
        trap(32'h0000_0044, 32'd0, 1'b0, 1'b0, 1'b1, 32'd11, 32'd0, 1);
        ret(32'h0000_0044, 1'b1);
        check("df_set", {31'd0, double_fault}, 32'd1);
        check("df_mcause", mcause, 32'd11);
        check("df_mtval", mtval, 32'd0);
        step(2);
        check("df_sticky", {31'd0, double_fault}, 32'd1);

        // async reset while in REDIRECT
        begin
            entry_t e;
            e.pc = 32'h0000_0500; e.cause = 32'd11; e.tval = 32'd0;
            entry_q.push_back(e);
        end
        exception_pc = 32'h0000_0500;
        ecall = 1'b1;
        step(1);
        ecall = 1'b0;
        step(1);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        step(1);
        check("async_no_redir", {31'd0, pc_redirect}, 32'd0);
        reset = 1'b1;
        step(3);
        check_all_zero("after_async");

        check("entry_q_empty", entry_q.size(), 32'd0);
        check("redir_q_empty", redir_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
